fp_alu_sequencer: RTL and testbench

Byte-serial sequencer for the 32-bit floating-point ALU core. It assembles two 32-bit operands from an 8-bit input stream and latches the opcode. It issues a single start pulse to the core, waits for the core's done, then streams the 32-bit result out one byte at a time under a valid/ready handshake. It sits between the pin-level wrapper and the arithmetic core, replacing the wrapper's direct start/done wiring.

---
 rtl/fp_alu_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_fp_alu_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_sequencer.sv
// Byte-serial operand/result sequencer for the 32-bit FP ALU core.
// Define FP_SEQ_WATCHDOG_EN to compile in the WAIT-state watchdog (abort to ERR after TIMEOUT_CYCLES).
module fp_alu_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        opcode,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  state_out,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic        core_op,
    output logic        core_start,
    input  logic [31:0] core_result,
    input  logic        core_done
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD_A = 4'd1,
        S_LOAD_B = 4'd2,
        S_ISSUE  = 4'd3,
        S_WAIT   = 4'd4,
        S_DRAIN  = 4'd5,
        S_DONE   = 4'd6,
        S_ERR    = 4'd7
    } state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] res_q;
    logic        op_q;
    logic [7:0]  out_data_q;
    logic        out_valid_q;
    logic        busy_q;
    logic        done_q;
    logic        start_q;

`ifdef FP_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            error_q;
`endif

    // Sequencer FSM with all outputs registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            res_q       <= 32'd0;
            op_q        <= 1'b0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
`ifdef FP_SEQ_WATCHDOG_EN
            wd_q        <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q[7:0] <= in_data;
                        op_q     <= opcode;
                        cnt_q    <= 2'd1;
                        busy_q   <= 1'b1;
                        state_q  <= S_LOAD_A;
`ifdef FP_SEQ_WATCHDOG_EN
                        error_q  <= 1'b0;
`endif
                    end
                end
                S_LOAD_A: begin
                    if (in_valid) begin
                        a_q[{cnt_q, 3'b000} +: 8] <= in_data;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= S_LOAD_B;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (in_valid) begin
                        b_q[{cnt_q, 3'b000} +: 8] <= in_data;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            start_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
`ifdef FP_SEQ_WATCHDOG_EN
                    wd_q    <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // core_done takes priority over an expiring watchdog
                    if (core_done) begin
                        res_q       <= core_result;
                        out_data_q  <= core_result[7:0];
                        out_valid_q <= 1'b1;
                        cnt_q       <= 2'd0;
                        state_q     <= S_DRAIN;
                    end
`ifdef FP_SEQ_WATCHDOG_EN
                    else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        error_q <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (cnt_q == 2'd3) begin
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            cnt_q       <= 2'd0;
                            state_q     <= S_DONE;
                        end else begin
                            out_data_q <= res_q[{cnt_q + 2'd1, 3'b000} +: 8];
                            cnt_q      <= cnt_q + 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state_out  = state_q;
    assign core_a     = a_q;
    assign core_b     = b_q;
    assign core_op    = op_q;
    assign core_start = start_q;
`ifdef FP_SEQ_WATCHDOG_EN
    assign error      = error_q;
`else
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_fp_alu_sequencer.sv
// Self-checking bench for fp_alu_sequencer: directed frames plus randomized frames
// against a little-endian byte/word reference model; FP_SEQ_WATCHDOG_EN selects watchdog checks.
module tb_fp_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        opcode = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  state_out;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_op;
    logic        core_start;
    logic [31:0] core_result = 32'd0;
    logic        core_done = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    logic stray = 1'b0;

    fp_alu_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .opcode(opcode),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .error(error), .state_out(state_out),
        .core_a(core_a), .core_b(core_b), .core_op(core_op), .core_start(core_start),
        .core_result(core_result), .core_done(core_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
        return 8'((w >> (8 * i)) & 32'hFF);
    endfunction

    task automatic send_operands(input logic [31:0] a, input logic [31:0] b, input logic op,
                                 input int max_gap);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = (i < 4) ? byte_of(a, i) : byte_of(b, i - 4);
            opcode   = (i == 0) ? op : ~op;
            @(negedge clk);
            if (i == 0) begin
                check("first_byte_state", 32'(state_out), 32'd1);
                check("first_byte_busy", 32'(busy), 32'd1);
                check("first_byte_error_clear", 32'(error), 32'd0);
            end
        end
        in_valid = stray;
        in_data  = 8'hFF;
    endtask

    task automatic check_issue(input logic [31:0] a, input logic [31:0] b, input logic op);
        check("issue_state", 32'(state_out), 32'd3);
        check("issue_start", 32'(core_start), 32'd1);
        check("core_a", core_a, a);
        check("core_b", core_b, b);
        check("core_op", 32'(core_op), 32'(op));
        @(negedge clk);
        check("wait_state", 32'(state_out), 32'd4);
        check("start_one_cycle", 32'(core_start), 32'd0);
    endtask

    task automatic respond(input logic [31:0] res, input int delay);
        repeat (delay) @(negedge clk);
        core_done   = 1'b1;
        core_result = res;
        @(negedge clk);
        core_done   = 1'b0;
        core_result = $urandom;
        check("drain_state", 32'(state_out), 32'd5);
    endtask

    task automatic drain(input logic [31:0] res, input int stall);
        int cyc = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_byte", 32'(out_data), 32'(byte_of(res, i)));
            if (i == 1 && stall > 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    cyc++;
                    check("stall_valid_hold", 32'(out_valid), 32'd1);
                    check("stall_data_hold", 32'(out_data), 32'(byte_of(res, 1)));
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        check("done_latency", 32'(cyc), 32'(4 + stall));
        check("done_pulse", 32'(done), 32'd1);
        check("done_state", 32'(state_out), 32'd6);
        check("done_no_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic finish_frame(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b0;
        check("idle_state", 32'(state_out), 32'd0);
        check("idle_done_low", 32'(done), 32'd0);
        check("idle_busy_low", 32'(busy), 32'd0);
        check("core_a_stable", core_a, a);
        check("core_b_stable", core_b, b);
    endtask

    task automatic run_frame(input logic [31:0] a, input logic [31:0] b, input logic op,
                             input logic [31:0] res, input int delay, input int stall,
                             input int max_gap);
        send_operands(a, b, op, max_gap);
        check_issue(a, b, op);
        respond(res, delay);
        drain(res, stall);
        finish_frame(a, b);
    endtask

    initial begin
        logic [31:0] ra, rb, rr;
        logic        rop;

        #1;
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_outs", {out_data, 16'd0, out_valid, busy, done, error, core_op, core_start, 2'd0}, 32'd0);
        check("rst_core_a", core_a, 32'd0);
        check("rst_core_b", core_b, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1.0 + 2.0 = 3.0, core answers three cycles after start
        run_frame(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 2, 0, 0);
        // same frame with 5 cycles of backpressure on byte 1
        run_frame(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 2, 5, 0);
        // stray FF input during ISSUE/WAIT/DRAIN/DONE must be dropped
        stray = 1'b1;
        run_frame(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hCAFE_F00D, 3, 1, 0);
        stray = 1'b0;

        // core never answers
        send_operands(32'h1111_2222, 32'h3333_4444, 1'b0, 0);
        check_issue(32'h1111_2222, 32'h3333_4444, 1'b0);
`ifdef FP_SEQ_WATCHDOG_EN
        repeat (7) @(negedge clk);
        check("wd_wait_cycle8", 32'(state_out), 32'd4);
        @(negedge clk);
        check("wd_err_state", 32'(state_out), 32'd7);
        check("wd_error", 32'(error), 32'd1);
        check("wd_no_valid", 32'(out_valid), 32'd0);
        check("wd_no_done", 32'(done), 32'd0);
        @(negedge clk);
        check("wd_back_idle", 32'(state_out), 32'd0);
        check("wd_error_sticky", 32'(error), 32'd1);
        check("wd_busy_low", 32'(busy), 32'd0);
        run_frame(32'h4000_0000, 32'h4040_0000, 1'b1, 32'h40C0_0000, 0, 0, 0);
`else
        repeat (30) @(negedge clk);
        check("nowd_still_wait", 32'(state_out), 32'd4);
        check("nowd_error_zero", 32'(error), 32'd0);
        check("nowd_no_valid", 32'(out_valid), 32'd0);
        respond(32'h0BAD_BEEF, 0);
        drain(32'h0BAD_BEEF, 0);
        finish_frame(32'h1111_2222, 32'h3333_4444);
`endif

        // core_done coincides with the last watchdog cycle: result still drains
        send_operands(32'hAAAA_5555, 32'h0F0F_F0F0, 1'b1, 0);
        check_issue(32'hAAAA_5555, 32'h0F0F_F0F0, 1'b1);
        respond(32'h8765_4321, 7);
        check("coincide_error", 32'(error), 32'd0);
        drain(32'h8765_4321, 0);
        finish_frame(32'hAAAA_5555, 32'h0F0F_F0F0);

        // reset after 5 operand bytes, then 2.0 * 3.0
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h10 + i);
            opcode   = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_state", 32'(state_out), 32'd0);
        check("midrst_outs", {out_data, 16'd0, out_valid, busy, done, error, core_op, core_start, 2'd0}, 32'd0);
        check("midrst_core_a", core_a, 32'd0);
        check("midrst_core_b", core_b, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame(32'h4000_0000, 32'h4040_0000, 1'b1, 32'h40C0_0000, 1, 0, 0);

        // randomized frames
        for (int n = 0; n < 12; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            rr  = $urandom;
            rop = 1'($urandom_range(0, 1));
            stray = 1'($urandom_range(0, 1));
            run_frame(ra, rb, rop, rr, $urandom_range(0, 5), $urandom_range(0, 3), 2);
            stray = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
